safe_access_ctrl: RTL and testbench
===================================

Name: safe_access_ctrl

Overview:
- Sequencer and arbiter in front of one PIN safe: 8-bit `din`/`din_valid` input, one-cycle-per-byte PIN entry, `unlocked` status output, synchronous `reset`.
- Shares the safe among NUM_REQ requesters with round-robin arbitration.
- Streams each granted 32-bit PIN into the safe as four bytes, checks the result and reports pass/fail to the requester.
- Holds the door open for a fixed time, enforces a cooldown after failures and latches a permanent lockout after MAX_FAILS consecutive failures.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- OPEN_CYCLES, 16, cycles the door stays open after a successful attempt (>=1).
- COOLDOWN_CYCLES, 8, cycles of penalty after a failed attempt (>=1).
- MAX_FAILS, 3, consecutive failures that trigger permanent lockout (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- pin  in  32*NUM_REQ  per-requester PIN; requester i uses slice [32i+31:32i]; byte 3 is sent first.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- ok  out  1  result qualifier, valid when any done bit is high; 1 = PIN accepted.
- door_open  out  1  high while in OPEN.
- locked_out  out  1  high in LOCKED.
- safe_din  out  8  byte to the safe.
- safe_din_valid  out  1  byte strobe to the safe.
- safe_rst  out  1  reset to the safe; holds the safe at its first-PIN state.
- safe_unlocked  in  1  unlocked status from the safe.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Values on reset:
  - state = IDLE; arbitration pointer last = NUM_REQ-1, so requester 0 wins first; fail_cnt = 0.
  - done = 0, ok = 0, door_open = 0, locked_out = 0, safe_din_valid = 0, safe_din = 0, safe_rst = 1.
- States: IDLE, SEND, CHECK, OPEN, COOLDOWN, LOCKED.
- Outputs are decoded from registered state and counters only; there is no combinational path from req/pin to outputs.
- safe_rst = 1 in IDLE, OPEN, COOLDOWN and LOCKED; 0 in SEND and CHECK. The safe is therefore always at its first-PIN state when an attempt starts.
- IDLE:
  - If any req bit is set, pick the first set bit strictly after `last`, wrapping.
  - Latch that requester's index and pin, set last = index, go to SEND with byte counter = 0.
  - Otherwise stay in IDLE.
- SEND (exactly 4 cycles):
  - safe_din_valid = 1; safe_din = latched pin byte 3, 2, 1, 0 on counter 0..3.
  - After counter 3, go to CHECK.
- CHECK (1 cycle):
  - safe_din_valid = 0; sample safe_unlocked.
  - done[grant] = 1 and ok = safe_unlocked this cycle.
  - Pass: fail_cnt cleared, go to OPEN.
  - Fail: fail_cnt+1; if the new value equals MAX_FAILS go to LOCKED, else go to COOLDOWN.
- Latency: req sampled in IDLE at cycle 0 → SEND cycles 1–4 → done/ok at cycle 5.
- OPEN: door_open = 1 for exactly OPEN_CYCLES cycles, then IDLE. The safe is re-reset here; safe_unlocked must drop the cycle after OPEN is entered.
- COOLDOWN: exactly COOLDOWN_CYCLES cycles, then IDLE. Requests are not granted.
- LOCKED: locked_out = 1; terminal until reset; no grants and no done pulses.
- Handshake:
  - Requester holds req until it sees its done.
  - pin only needs to be stable in the grant cycle; it is latched.
  - If req drops mid-attempt, the attempt still completes and done still pulses.
  - A requester that keeps req high after done re-competes in the next IDLE; round-robin prevents starvation.
- Counters: dwell counter width $clog2(max(OPEN_CYCLES, COOLDOWN_CYCLES)+1); fail_cnt width $clog2(MAX_FAILS+1); both saturate and never wrap.
- Reset mid-operation: returns to IDLE immediately. Any in-flight attempt is dropped with no done pulse. fail_cnt and lockout are cleared.
- A safe_unlocked observed high outside CHECK/OPEN is ignored.

Optional Feature:
- Macro: SAFE_CTRL_AUDIT_EN.
- When defined:
  - Adds output attempt_cnt (16 bits): +1 on every CHECK cycle, saturates at 0xFFFF.
  - Adds output fail_total (16 bits): +1 on every failed CHECK, saturates.
  - Both are 0 on reset.
- When undefined, neither port nor the registers exist. Core behaviour is identical either way.

Test Plan:
- Single requester 0, pin = 0xBAADC0DE: safe_din = BA, AD, C0, DE with valid on cycles 1–4; done[0] = 1, ok = 1 at cycle 5; door_open high for 16 cycles; then IDLE with safe_rst = 1.
- Wrong pin 0xBAADC0DF: done[0] = 1, ok = 0 at cycle 5; 8 cooldown cycles with no grant although req is held; then regrant.
- Three consecutive wrong pins: locked_out = 1 after the third CHECK. A subsequent correct pin is never granted. reset clears locked_out and next grant goes to requester 0.
- req = 2'b11 held continuously: grants alternate 0, 1, 0, 1; each done pulses only for its grantee.
- Two wrong pins, then a correct one, then a wrong one: no lockout (fail_cnt cleared by the success).
- reset asserted during SEND byte 2: no done pulse; safe_rst = 1 and all outputs at reset values next cycle. With SAFE_CTRL_AUDIT_EN, attempt_cnt is unchanged by the aborted attempt.

Source files
------------

// File: rtl/safe_access_ctrl.sv
// Round-robin sequencer in front of a single PIN safe: streams a granted 32-bit PIN
// as four bytes, reports pass/fail, then holds open, cools down or locks out.
// Optional audit counters are built when SAFE_CTRL_AUDIT_EN is defined.
module safe_access_ctrl #(
    parameter int NUM_REQ         = 2,
    parameter int OPEN_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int MAX_FAILS       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [32*NUM_REQ-1:0] pin,
    output logic [NUM_REQ-1:0]   done,
    output logic                 ok,
    output logic                 door_open,
    output logic                 locked_out,
    output logic [7:0]           safe_din,
    output logic                 safe_din_valid,
    output logic                 safe_rst,
    input  logic                 safe_unlocked
`ifdef SAFE_CTRL_AUDIT_EN
    ,
    output logic [15:0]          attempt_cnt,
    output logic [15:0]          fail_total
`endif
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int DWELL_MAX = (OPEN_CYCLES > COOLDOWN_CYCLES) ? OPEN_CYCLES : COOLDOWN_CYCLES;
    localparam int DW_W      = $clog2(DWELL_MAX + 1);
    localparam int FC_W      = $clog2(MAX_FAILS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_CHECK, S_OPEN, S_COOLDOWN, S_LOCKED
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] last, grant;
    logic [31:0]      pin_q;
    logic [1:0]       byte_cnt;
    logic [DW_W-1:0]  dwell;
    logic [FC_W-1:0]  fail_cnt, fail_inc;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx, cand;
    int               j;

    // Scan downwards so the last hit is the first set bit after 'last'.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        j          = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j    = (int'(last) + i) % NUM_REQ;
            cand = IDX_W'(j);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign fail_inc = (fail_cnt == FC_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (pick_valid) state_next = S_SEND;
            S_SEND:     if (byte_cnt == 2'd3) state_next = S_CHECK;
            S_CHECK: begin
                if (safe_unlocked)                     state_next = S_OPEN;
                else if (fail_inc == FC_W'(MAX_FAILS)) state_next = S_LOCKED;
                else                                   state_next = S_COOLDOWN;
            end
            S_OPEN:     if (dwell == DW_W'(OPEN_CYCLES - 1)) state_next = S_IDLE;
            S_COOLDOWN: if (dwell == DW_W'(COOLDOWN_CYCLES - 1)) state_next = S_IDLE;
            S_LOCKED:   state_next = S_LOCKED;
            default:    state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            last     <= IDX_W'(NUM_REQ - 1);
            grant    <= '0;
            pin_q    <= '0;
            byte_cnt <= '0;
            dwell    <= '0;
            fail_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: if (pick_valid) begin
                    grant    <= pick_idx;
                    last     <= pick_idx;
                    pin_q    <= pin[32*pick_idx +: 32];
                    byte_cnt <= '0;
                end
                S_SEND:  byte_cnt <= byte_cnt + 2'd1;
                S_CHECK: begin
                    dwell    <= '0;
                    fail_cnt <= safe_unlocked ? '0 : fail_inc;
                end
                S_OPEN, S_COOLDOWN:
                    if (dwell != DW_W'(DWELL_MAX)) dwell <= dwell + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SAFE_CTRL_AUDIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            attempt_cnt <= '0;
            fail_total  <= '0;
        end else if (state == S_CHECK) begin
            if (attempt_cnt != 16'hFFFF) attempt_cnt <= attempt_cnt + 16'd1;
            if (!safe_unlocked && fail_total != 16'hFFFF) fail_total <= fail_total + 16'd1;
        end
    end
`endif

    // Outputs depend only on registered state, apart from ok echoing the safe in CHECK.
    always_comb begin
        safe_din_valid = (state == S_SEND);
        safe_din       = (state == S_SEND) ? pin_q[{~byte_cnt, 3'b000} +: 8] : 8'h00;
        safe_rst       = !((state == S_SEND) || (state == S_CHECK));
        done           = (state == S_CHECK) ? (NUM_REQ'(1) << grant) : '0;
        ok             = (state == S_CHECK) && safe_unlocked;
        door_open      = (state == S_OPEN);
        locked_out     = (state == S_LOCKED);
    end

endmodule

// File: tb/tb_safe_access_ctrl.sv
// Directed bench for safe_access_ctrl with a behavioural PIN safe whose secret is 0xBAADC0DE.
module tb_safe_access_ctrl;

    localparam logic [31:0] SECRET = 32'hBAADC0DE;
    localparam logic [31:0] WRONG  = 32'hBAADC0DF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [63:0] pin_bus = '0;
    logic [1:0]  done;
    logic        ok, door_open, locked_out, safe_din_valid, safe_rst;
    logic [7:0]  safe_din;
    logic        safe_unlocked = 1'b0;
`ifdef SAFE_CTRL_AUDIT_EN
    logic [15:0] attempt_cnt, fail_total;
`endif

    int total = 0;
    int bad   = 0;

    safe_access_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .pin(pin_bus),
        .done(done), .ok(ok), .door_open(door_open), .locked_out(locked_out),
        .safe_din(safe_din), .safe_din_valid(safe_din_valid), .safe_rst(safe_rst),
        .safe_unlocked(safe_unlocked)
`ifdef SAFE_CTRL_AUDIT_EN
        , .attempt_cnt(attempt_cnt), .fail_total(fail_total)
`endif
    );

    always #5 clk = ~clk;

    // Safe model: unlocks after four bytes matching SECRET, held in reset by safe_rst.
    logic [23:0] s_shift = '0;
    logic [1:0]  s_cnt   = '0;
    always @(posedge clk) begin
        if (safe_rst) begin
            s_cnt         <= '0;
            safe_unlocked <= 1'b0;
        end else if (safe_din_valid) begin
            s_shift <= {s_shift[15:0], safe_din};
            s_cnt   <= s_cnt + 2'd1;
            if (s_cnt == 2'd3) safe_unlocked <= ({s_shift, safe_din} == SECRET);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(output logic [1:0] d, output logic o, output bit timeout);
        timeout = 1'b1;
        d = 2'b00;
        o = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done !== 2'b00) begin
                d = done;
                o = ok;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({done, ok, door_open, locked_out, safe_din_valid, safe_din, safe_rst} !== 15'b000000000000001) begin
            bad++;
            $display("FAIL reset_outputs got done=%b ok=%b door=%b lock=%b v=%b din=%h rst=%b want all 0 rst=1",
                     done, ok, door_open, locked_out, safe_din_valid, safe_din, safe_rst);
        end
    endtask

    task automatic test_pass();
        logic [7:0] exp_b [4] = '{8'hBA, 8'hAD, 8'hC0, 8'hDE};
        int door_cnt;
        do_reset();
        pin_bus[31:0] = SECRET;
        req = 2'b01;
        step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (safe_din_valid !== 1'b1 || safe_din !== exp_b[k] || safe_rst !== 1'b0 || done !== 2'b00) begin
                bad++;
                $display("FAIL pass_byte%0d got v=%b din=%h rst=%b want v=1 din=%h rst=0", k,
                         safe_din_valid, safe_din, safe_rst, exp_b[k]);
            end
            step();
        end
        total++;
        if (done !== 2'b01 || ok !== 1'b1 || safe_din_valid !== 1'b0) begin
            bad++;
            $display("FAIL pass_done got done=%b ok=%b v=%b want done=01 ok=1 v=0", done, ok, safe_din_valid);
        end
        req = 2'b00;
        step();
        door_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (door_open === 1'b1) door_cnt++;
            step();
        end
        total++;
        if (door_cnt != 16) begin
            bad++;
            $display("FAIL pass_door_cycles got %0d want 16", door_cnt);
        end
        total++;
        if (door_open !== 1'b0 || safe_rst !== 1'b1 || safe_din_valid !== 1'b0) begin
            bad++;
            $display("FAIL pass_idle got door=%b rst=%b v=%b want 0 1 0", door_open, safe_rst, safe_din_valid);
        end
    endtask

    task automatic test_fail_cooldown();
        bit stray;
        do_reset();
        pin_bus[31:0] = WRONG;
        req = 2'b01;
        for (int k = 0; k < 5; k++) step();
        total++;
        if (done !== 2'b01 || ok !== 1'b0) begin
            bad++;
            $display("FAIL fail_done got done=%b ok=%b want done=01 ok=0", done, ok);
        end
        stray = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (safe_din_valid !== 1'b0 || done !== 2'b00 || safe_rst !== 1'b1 || door_open !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL fail_cooldown got activity=1 want quiet for 8 cycles");
        end
        step();
        total++;
        if (safe_din_valid !== 1'b0) begin
            bad++;
            $display("FAIL fail_idle_gap got v=%b want 0", safe_din_valid);
        end
        step();
        total++;
        if (safe_din_valid !== 1'b1 || safe_din !== 8'hBA) begin
            bad++;
            $display("FAIL fail_regrant got v=%b din=%h want v=1 din=ba", safe_din_valid, safe_din);
        end
        req = 2'b00;
    endtask

    task automatic test_lockout();
        logic [1:0] d;
        logic o;
        bit to, stray;
        do_reset();
        pin_bus[31:0] = WRONG;
        req = 2'b01;
        for (int n = 0; n < 3; n++) begin
            wait_done(d, o, to);
            total++;
            if (to || d !== 2'b01 || o !== 1'b0) begin
                bad++;
                $display("FAIL lock_attempt%0d got done=%b ok=%b timeout=%0d want done=01 ok=0", n, d, o, to);
            end
        end
        step();
        total++;
        if (locked_out !== 1'b1 || safe_rst !== 1'b1) begin
            bad++;
            $display("FAIL lock_entered got lock=%b rst=%b want 1 1", locked_out, safe_rst);
        end
        pin_bus[31:0] = SECRET;
        stray = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done !== 2'b00 || safe_din_valid !== 1'b0 || locked_out !== 1'b1) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL lock_terminal got activity=1 want locked and idle");
        end
        reset = 1'b1;
        req = 2'b11;
        pin_bus[63:32] = SECRET;
        step();
        total++;
        if (locked_out !== 1'b0 || safe_rst !== 1'b1) begin
            bad++;
            $display("FAIL lock_reset got lock=%b rst=%b want 0 1", locked_out, safe_rst);
        end
        reset = 1'b0;
        wait_done(d, o, to);
        total++;
        if (to || d !== 2'b01 || o !== 1'b1) begin
            bad++;
            $display("FAIL lock_first_grant got done=%b ok=%b timeout=%0d want done=01 ok=1", d, o, to);
        end
        req = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0] d;
        logic o;
        bit to;
        logic [1:0] exp_d [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        pin_bus = {SECRET, SECRET};
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_done(d, o, to);
            total++;
            if (to || d !== exp_d[n] || o !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant%0d got done=%b ok=%b timeout=%0d want done=%b ok=1", n, d, o, to, exp_d[n]);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_fail_clear();
        logic [1:0] d;
        logic o;
        bit to;
        logic [31:0] seq [4] = '{WRONG, WRONG, SECRET, WRONG};
        logic        exp_ok [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        req = 2'b01;
        for (int n = 0; n < 4; n++) begin
            pin_bus[31:0] = seq[n];
            wait_done(d, o, to);
            total++;
            if (to || d !== 2'b01 || o !== exp_ok[n]) begin
                bad++;
                $display("FAIL clr_attempt%0d got done=%b ok=%b timeout=%0d want done=01 ok=%b", n, d, o, to, exp_ok[n]);
            end
        end
        req = 2'b00;
        step();
        total++;
        if (locked_out !== 1'b0) begin
            bad++;
            $display("FAIL clr_no_lockout got lock=%b want 0", locked_out);
        end
    endtask

    task automatic test_reset_mid();
        bit stray;
        do_reset();
        pin_bus[31:0] = SECRET;
        req = 2'b01;
        step();
        step();
        step();
        total++;
        if (safe_din_valid !== 1'b1 || safe_din !== 8'hC0) begin
            bad++;
            $display("FAIL mid_byte2 got v=%b din=%h want v=1 din=c0", safe_din_valid, safe_din);
        end
        reset = 1'b1;
        req = 2'b00;
        step();
        total++;
        if ({done, ok, door_open, locked_out, safe_din_valid, safe_din, safe_rst} !== 15'b000000000000001) begin
            bad++;
            $display("FAIL mid_reset_outputs got done=%b v=%b din=%h rst=%b want 00 0 00 1",
                     done, safe_din_valid, safe_din, safe_rst);
        end
        reset = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done !== 2'b00 || safe_din_valid !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL mid_no_done got activity=1 want none");
        end
`ifdef SAFE_CTRL_AUDIT_EN
        total++;
        if (attempt_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_attempt_cnt got %0d want 0", attempt_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_cooldown();
        test_lockout();
        test_round_robin();
        test_fail_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
